lcd_ctrl: RTL and testbench

- Downstream consumer of the data memory's io_lcd output register.
- Turns software-written LCD request words into correctly timed HD44780-style 8-bit write cycles on the LCD pins: setup, enable pulse, hold, then execution wait.
- After reset it runs the LCD power-up delay and a fixed 4-command init sequence before it accepts software requests.
- Reports busy, init-done and overflow status for software polling.

---
 rtl/lcd_ctrl.sv | 273 +++++++++++++++++++++++++++
 tb/tb_lcd_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_ctrl.sv
// -----------------------------------------------------------------------------
// lcd_ctrl
//
// Purpose:
//   Consumes the data memory's io_lcd output register and turns software
//   request words into HD44780-style 8-bit write cycles on the LCD pins:
//   setup, enable pulse, hold, then the execution wait the LCD needs before it
//   accepts the next write. After reset it waits the LCD power-up time and
//   issues a fixed 4-command init sequence. Only after that do software
//   requests reach the pins. Requests that arrive earlier, or while a write is
//   in flight, are held in a one-deep pending slot. A request that finds that
//   slot full is dropped and flagged.
//
// Ports:
//   clk_i        in   1   system clock
//   rst_ni       in   1   asynchronous active-low reset
//   io_lcd_i     in  32   request word: [31] LCD on, [10] start (rising edge),
//                         [9] RS, [7:0] data; other bits unused
//   lcd_on_o     out  1   LCD power/backlight (io_lcd_i[31], one cycle later)
//   lcd_en_o     out  1   LCD E pin
//   lcd_rs_o     out  1   LCD RS pin
//   lcd_rw_o     out  1   LCD RW pin, always write (0)
//   lcd_data_o   out  8   LCD DB[7:0]
//   busy_o       out  1   controller not idle or a request is pending
//   init_done_o  out  1   init sequence has completed
//   ovf_o        out  1   sticky: a request was dropped
// -----------------------------------------------------------------------------
module lcd_ctrl #(
    parameter int T_PWRUP = 750000,
    parameter int T_SETUP = 4,
    parameter int T_PULSE = 25,
    parameter int T_HOLD  = 4,
    parameter int T_EXEC  = 2000,
    parameter int T_CLEAR = 82000,
    parameter int CW      = 20
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] io_lcd_i,
    output logic        lcd_on_o,
    output logic        lcd_en_o,
    output logic        lcd_rs_o,
    output logic        lcd_rw_o,
    output logic [7:0]  lcd_data_o,
    output logic        busy_o,
    output logic        init_done_o,
    output logic        ovf_o
);

    typedef enum logic [2:0] {
        S_PWRUP,
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_EXEC
    } state_t;

    // A state lasting N cycles is entered with the counter at N-1 and left on
    // the cycle the counter reads zero.
    localparam logic [CW-1:0] L_PWRUP = CW'(T_PWRUP - 1);
    localparam logic [CW-1:0] L_SETUP = CW'(T_SETUP - 1);
    localparam logic [CW-1:0] L_PULSE = CW'(T_PULSE - 1);
    localparam logic [CW-1:0] L_HOLD  = CW'(T_HOLD - 1);
    localparam logic [CW-1:0] L_EXEC  = CW'(T_EXEC - 1);
    localparam logic [CW-1:0] L_CLEAR = CW'(T_CLEAR - 1);

    // Init sequence: 8-bit/2-line, display on, clear, entry mode increment.
    function automatic logic [7:0] init_word(input logic [1:0] idx);
        logic [7:0] w;
        case (idx)
            2'd0:    w = 8'h38;
            2'd1:    w = 8'h0C;
            2'd2:    w = 8'h01;
            default: w = 8'h06;
        endcase
        return w;
    endfunction

    // Registers
    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_init_idx;
    logic          r_pend;
    logic [8:0]    r_pend_word;   // {RS, data}
    logic          r_start_q;
    logic          r_on;
    logic          r_en;
    logic          r_rs;
    logic [7:0]    r_data;
    logic          r_busy;
    logic          r_init_done;
    logic          r_ovf;

    // Next-state / combinational wires
    state_t        w_state_nx;
    logic [CW-1:0] w_cnt_nx;
    logic [1:0]    w_init_idx_nx;
    logic          w_pend_nx;
    logic [8:0]    w_pend_word_nx;
    logic          w_rs_nx;
    logic [7:0]    w_data_nx;
    logic          w_init_done_nx;
    logic          w_ovf_nx;
    logic          w_accept;
    logic          w_req;
    logic [8:0]    w_req_word;
    logic          w_cnt_zero;
    logic          w_is_clear;
    logic [CW-1:0] w_exec_load;
    logic          w_unused;

    assign w_req      = io_lcd_i[10] & ~r_start_q;
    assign w_req_word = {io_lcd_i[9], io_lcd_i[7:0]};
    assign w_cnt_zero = (r_cnt == '0);

    // Clear and home need the long execution wait. RS and data are stable
    // from SETUP onwards, so the word driving the pins decides the wait.
    assign w_is_clear  = ~r_rs & ((r_data == 8'h01) | (r_data == 8'h02));
    assign w_exec_load = w_is_clear ? L_CLEAR : L_EXEC;

    // Bit 8 and the reserved bits of the dmem register carry no meaning here.
    assign w_unused = ^{io_lcd_i[30:11], io_lcd_i[8]};

    // -------------------------------------------------------------------------
    // Next-state, counter, queue and status logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nx     = r_state;
        w_cnt_nx       = w_cnt_zero ? r_cnt : (r_cnt - CW'(1));
        w_init_idx_nx  = r_init_idx;
        w_pend_nx      = r_pend;
        w_pend_word_nx = r_pend_word;
        w_rs_nx        = r_rs;
        w_data_nx      = r_data;
        w_init_done_nx = r_init_done;
        w_ovf_nx       = r_ovf;
        w_accept       = 1'b0;

        case (r_state)
            S_PWRUP: begin
                if (w_cnt_zero) begin
                    w_state_nx    = S_SETUP;
                    w_cnt_nx      = L_SETUP;
                    w_init_idx_nx = 2'd0;
                    w_rs_nx       = 1'b0;
                    w_data_nx     = init_word(2'd0);
                end
            end

            S_IDLE: begin
                // The pending slot is served first; a request arriving in the
                // same cycle refills the slot freed here.
                if (r_pend) begin
                    w_state_nx             = S_SETUP;
                    w_cnt_nx               = L_SETUP;
                    {w_rs_nx, w_data_nx}   = r_pend_word;
                    w_pend_nx              = 1'b0;
                end else if (w_req && r_init_done) begin
                    w_state_nx             = S_SETUP;
                    w_cnt_nx               = L_SETUP;
                    {w_rs_nx, w_data_nx}   = w_req_word;
                    w_accept               = 1'b1;
                end else begin
                    w_cnt_nx = '0;
                end
            end

            S_SETUP: begin
                if (w_cnt_zero) begin
                    w_state_nx = S_PULSE;
                    w_cnt_nx   = L_PULSE;
                end
            end

            S_PULSE: begin
                if (w_cnt_zero) begin
                    w_state_nx = S_HOLD;
                    w_cnt_nx   = L_HOLD;
                end
            end

            S_HOLD: begin
                if (w_cnt_zero) begin
                    w_state_nx = S_EXEC;
                    w_cnt_nx   = w_exec_load;
                end
            end

            S_EXEC: begin
                if (w_cnt_zero) begin
                    if (r_init_idx != 2'd3) begin
                        // Still inside the init sequence: chain the next word.
                        w_init_idx_nx = r_init_idx + 2'd1;
                        w_state_nx    = S_SETUP;
                        w_cnt_nx      = L_SETUP;
                        w_rs_nx       = 1'b0;
                        w_data_nx     = init_word(r_init_idx + 2'd1);
                    end else begin
                        // Last init word or a software write has finished.
                        // The index stays at 3 so later writes end here too.
                        w_state_nx     = S_IDLE;
                        w_cnt_nx       = '0;
                        w_init_done_nx = 1'b1;
                    end
                end
            end

            default: begin
                w_state_nx = S_PWRUP;
                w_cnt_nx   = L_PWRUP;
            end
        endcase

        // A request not started directly goes to the pending slot, or is lost
        // if the slot is still occupied after this cycle's dispatch.
        if (w_req && !w_accept) begin
            if (!w_pend_nx) begin
                w_pend_nx      = 1'b1;
                w_pend_word_nx = w_req_word;
            end else begin
                w_ovf_nx = 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= S_PWRUP;
            r_cnt       <= L_PWRUP;
            r_init_idx  <= 2'd0;
            r_pend      <= 1'b0;
            r_pend_word <= '0;
            r_start_q   <= 1'b0;
            r_on        <= 1'b0;
            r_en        <= 1'b0;
            r_rs        <= 1'b0;
            r_data      <= '0;
            r_busy      <= 1'b1;
            r_init_done <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_cnt       <= w_cnt_nx;
            r_init_idx  <= w_init_idx_nx;
            r_pend      <= w_pend_nx;
            r_pend_word <= w_pend_word_nx;
            r_start_q   <= io_lcd_i[10];
            r_on        <= io_lcd_i[31];
            // EN and busy are registered from the next state so they switch
            // on the same edge as the state they describe.
            r_en        <= (w_state_nx == S_PULSE);
            r_rs        <= w_rs_nx;
            r_data      <= w_data_nx;
            r_busy      <= (w_state_nx != S_IDLE) | w_pend_nx;
            r_init_done <= w_init_done_nx;
            r_ovf       <= w_ovf_nx;
        end
    end

    assign lcd_on_o    = r_on;
    assign lcd_en_o    = r_en;
    assign lcd_rs_o    = r_rs;
    assign lcd_rw_o    = 1'b0;
    assign lcd_data_o  = r_data;
    assign busy_o      = r_busy;
    assign init_done_o = r_init_done;
    assign ovf_o       = r_ovf;

endmodule

// File: tb/tb_lcd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lcd_ctrl
//
// Self-checking bench for lcd_ctrl with short timing parameters. Every word
// expected on the LCD pins is pushed to a scoreboard queue when its stimulus
// is applied. A monitor pops and compares an entry at each EN rising edge and
// checks the pulse width. The main thread checks reset values, init timing,
// write/clear durations, pending/overflow behaviour and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_lcd_ctrl;

    localparam int T_PWRUP = 20;
    localparam int T_SETUP = 2;
    localparam int T_PULSE = 4;
    localparam int T_HOLD  = 2;
    localparam int T_EXEC  = 10;
    localparam int T_CLEAR = 30;
    localparam int CW      = 8;

    logic        clk;
    logic        rst_ni;
    logic [31:0] io_lcd_i;
    logic        lcd_on_o;
    logic        lcd_en_o;
    logic        lcd_rs_o;
    logic        lcd_rw_o;
    logic [7:0]  lcd_data_o;
    logic        busy_o;
    logic        init_done_o;
    logic        ovf_o;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          c0      = 0;
    logic [8:0]  sb[$];       // expected {RS, data} per EN pulse
    int          rise_q[$];   // EN rise cycle relative to reset release

    lcd_ctrl #(
        .T_PWRUP (T_PWRUP),
        .T_SETUP (T_SETUP),
        .T_PULSE (T_PULSE),
        .T_HOLD  (T_HOLD),
        .T_EXEC  (T_EXEC),
        .T_CLEAR (T_CLEAR),
        .CW      (CW)
    ) u_dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .io_lcd_i    (io_lcd_i),
        .lcd_on_o    (lcd_on_o),
        .lcd_en_o    (lcd_en_o),
        .lcd_rs_o    (lcd_rs_o),
        .lcd_rw_o    (lcd_rw_o),
        .lcd_data_o  (lcd_data_o),
        .busy_o      (busy_o),
        .init_done_o (init_done_o),
        .ovf_o       (ovf_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // EN pulse monitor / scoreboard consumer
    initial begin
        logic       en_prev;
        int         en_rise;
        logic [8:0] e;
        en_prev = 1'b0;
        en_rise = 0;
        forever begin
            @(negedge clk);
            if (!rst_ni) begin
                en_prev = 1'b0;
            end else begin
                if (lcd_en_o && !en_prev) begin
                    rise_q.push_back(cyc - c0);
                    chk("sb_has_entry", 32'(sb.size() != 0), 32'd1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        chk("pulse_word", {23'd0, lcd_rs_o, lcd_data_o}, {23'd0, e});
                    end
                    en_rise = cyc;
                end
                if (!lcd_en_o && en_prev)
                    chk("pulse_width", cyc - en_rise, T_PULSE);
                en_prev = lcd_en_o;
            end
        end
    end

    // Apply a request word, drop the start bit one cycle later and measure
    // busy length and EN window relative to the sampling edge.
    task automatic issue(input logic [31:0] w, output int blen, output int efirst,
                         output int elast, output logic [8:0] word1, output logic on1);
        io_lcd_i = w;
        blen     = 0;
        efirst   = 0;
        elast    = 0;
        word1    = '0;
        on1      = 1'b0;
        for (int i = 1; i <= 300; i++) begin
            tick();
            if (i == 1) begin
                word1    = {lcd_rs_o, lcd_data_o};
                on1      = lcd_on_o;
                io_lcd_i = w & 32'hFFFF_FBFF;
            end
            if (lcd_en_o) begin
                if (efirst == 0) efirst = i;
                elast = i;
            end
            if (!busy_o) break;
            blen = i;
        end
    endtask

    // Release reset and follow power-up plus the init sequence. With early set,
    // a request is raised during power-up and must run right after init.
    task automatic run_init(input bit early);
        logic en_seen;
        int   n;
        sb.delete();
        rise_q.delete();
        sb.push_back(9'h038);
        sb.push_back(9'h00C);
        sb.push_back(9'h001);
        sb.push_back(9'h006);
        rst_ni  = 1'b1;
        c0      = cyc;
        en_seen = 1'b0;
        for (int i = 1; i <= T_PWRUP; i++) begin
            tick();
            en_seen = en_seen | lcd_en_o;
            if (early && i == 5) begin
                io_lcd_i = 32'h0000_0645;
                sb.push_back(9'h145);
            end
            if (early && i == 6) io_lcd_i = 32'h0;
        end
        chk("pwrup_en_low", 32'(en_seen), 32'd0);
        chk("pwrup_busy", 32'(busy_o), 32'd1);
        while (cyc - c0 < 111) tick();
        chk("init_done_111", 32'(init_done_o), 32'd0);
        chk("busy_111", 32'(busy_o), 32'd1);
        tick();
        chk("init_done_112", 32'(init_done_o), 32'd1);
        chk("busy_112", 32'(busy_o), early ? 32'd1 : 32'd0);
        if (early) begin
            n = 0;
            while (busy_o && n < 200) begin
                tick();
                n++;
            end
            chk("early_idle_cycle", cyc - c0, 131);
            chk("early_rise", (rise_q.size() > 4) ? rise_q[4] : -1, 115);
            chk("early_no_ovf", 32'(ovf_o), 32'd0);
        end
        chk("init_pulse_count", rise_q.size(), early ? 5 : 4);
        for (int k = 0; k < 4; k++)
            chk("init_rise", (k < rise_q.size()) ? rise_q[k] : -1, (k == 3) ? 96 : 22 + 18 * k);
        chk("sb_empty_init", sb.size(), 0);
    endtask

    initial begin
        int         blen;
        int         efirst;
        int         elast;
        int         n;
        int         rq0;
        logic [8:0] word1;
        logic       on1;

        rst_ni   = 1'b0;
        io_lcd_i = 32'h0;
        repeat (3) tick();

        chk("rst_on", 32'(lcd_on_o), 32'd0);
        chk("rst_en", 32'(lcd_en_o), 32'd0);
        chk("rst_rs", 32'(lcd_rs_o), 32'd0);
        chk("rst_rw", 32'(lcd_rw_o), 32'd0);
        chk("rst_data", 32'(lcd_data_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd1);
        chk("rst_init_done", 32'(init_done_o), 32'd0);
        chk("rst_ovf", 32'(ovf_o), 32'd0);

        run_init(1'b0);
        tick();
        tick();

        // Data write 'A' with RS=1 and LCD on
        sb.push_back(9'h141);
        issue(32'h8000_0641, blen, efirst, elast, word1, on1);
        chk("wr_on", 32'(on1), 32'd1);
        chk("wr_word", 32'(word1), 32'h141);
        chk("wr_en_first", efirst, 3);
        chk("wr_en_last", elast, 6);
        chk("wr_busy_len", blen, 18);
        chk("wr_rw", 32'(lcd_rw_o), 32'd0);
        tick();

        // Clear command uses the long execution wait
        sb.push_back(9'h001);
        issue(32'h8000_0401, blen, efirst, elast, word1, on1);
        chk("clr_word", 32'(word1), 32'h001);
        chk("clr_en_first", efirst, 3);
        chk("clr_busy_len", blen, 38);
        chk("idle_retain", {23'd0, lcd_rs_o, lcd_data_o}, 32'h001);
        tick();

        // Three requests during one write: A runs, B pends, C is dropped
        chk("ovf_before", 32'(ovf_o), 32'd0);
        rq0 = rise_q.size();
        io_lcd_i = 32'h8000_0641;
        sb.push_back(9'h141);
        tick();
        io_lcd_i = 32'h8000_0000;
        tick();
        io_lcd_i = 32'h8000_0642;
        sb.push_back(9'h142);
        tick();
        io_lcd_i = 32'h8000_0000;
        tick();
        io_lcd_i = 32'h8000_0643;
        tick();
        io_lcd_i = 32'h8000_0000;
        tick();
        chk("ovf_set", 32'(ovf_o), 32'd1);
        n = 6;
        while (busy_o && n < 300) begin
            tick();
            n++;
        end
        chk("pend_busy_len", n - 1, 37);
        chk("pend_pulses", rise_q.size() - rq0, 2);
        chk("pend_sb_drained", sb.size(), 0);
        chk("pend_last_word", {23'd0, lcd_rs_o, lcd_data_o}, 32'h142);
        tick();

        // Overflow flag stays set across a later normal write
        sb.push_back(9'h144);
        issue(32'h8000_0644, blen, efirst, elast, word1, on1);
        chk("sticky_busy_len", blen, 18);
        chk("ovf_sticky", 32'(ovf_o), 32'd1);
        tick();

        // Reset while EN is high
        sb.push_back(9'h147);
        io_lcd_i = 32'h8000_0647;
        tick();
        io_lcd_i = 32'h8000_0000;
        n = 0;
        while (!lcd_en_o && n < 20) begin
            tick();
            n++;
        end
        chk("mid_en_high", 32'(lcd_en_o), 32'd1);
        rst_ni   = 1'b0;
        io_lcd_i = 32'h0;
        #1;
        chk("rst_en_async", 32'(lcd_en_o), 32'd0);
        chk("rst_busy_async", 32'(busy_o), 32'd1);
        chk("rst_init_done_async", 32'(init_done_o), 32'd0);
        chk("rst_ovf_async", 32'(ovf_o), 32'd0);
        tick();
        tick();

        // Restarted init with a request raised during power-up
        run_init(1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
